gcd_bus_master: RTL and testbench
=================================

// Module: gcd_bus_master
// PURPOSE
//  Bus initiator for the gpioemu register interface, driving the GCD peripheral from
//  fabric logic instead of a bench. Accepts an operand pair on a valid/ready port and
//  writes A1 (0xf8) then A2 (0xfc). Polls the status register until done, reads the
//  result and returns it on a valid/ready result port.
//  Sits between compute fabric and gpioemu; drives saddress/srd/swr/sdata_in.
// PARAMETERS
//  A1_ADDR      16'h00f8  operand A write address
//  A2_ADDR      16'h00fc  operand B write address (write starts the GCD)
//  STATUS_ADDR  16'h00f4  status read address; bit0 = 1 when result valid
//  RESULT_ADDR  16'h00f0  result read address
//  STROBE_CYC   2         cycles swr/srd held high (>=1)
//  POLL_LIMIT   1024      max status reads before timeout (>=1)
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  n_reset      in   1   asynchronous, active-low reset
//  op_valid     in   1   operand pair offered
//  op_ready     out  1   master idle, can accept operands
//  op_a         in   32  operand A
//  op_b         in   32  operand B
//  res_valid    out  1   result/timeout available
//  res_ready    in   1   consumer accepts result
//  res_data     out  32  GCD result (0 on timeout)
//  res_timeout  out  1   qualifies res_valid: poll limit exceeded
//  saddress     out  16  bus address to slave
//  srd          out  1   bus read strobe
//  swr          out  1   bus write strobe
//  sdata_wr     out  32  write data to slave (slave's sdata_in)
//  sdata_rd     in   32  read data from slave (slave's sdata_out)
// BEHAVIOUR
//  Reset: all outputs 0 except op_ready=1; FSM -> IDLE; operand/result regs cleared.
//  Bus cycle (every access): SETUP 1 cyc (addr/data driven, strobes 0) -> STROBE
//   STROBE_CYC cyc (swr or srd =1) -> HOLD 1 cyc (strobes 0, addr/data still held).
//   Reads sample sdata_rd on the last STROBE cycle. Never srd and swr high together.
//   Idle bus: saddress=0, sdata_wr=0.
//  FSM: IDLE -(op_valid&op_ready)-> WR_A1 -> WR_A2 -> RD_STAT -> {bit0=1: RD_RES;
//   else poll_cnt++ ; poll_cnt==POLL_LIMIT: DONE w/ timeout; else GAP} ;
//   GAP (1 idle cyc) -> RD_STAT ; RD_RES -> DONE ; DONE -(res_ready)-> IDLE.
//  op_ready=1 only in IDLE; operands captured on handshake cycle, later op_a/op_b
//   changes ignored.
//  res_valid=1 only in DONE; res_data/res_timeout stable while res_valid & !res_ready.
//  Handshake completes in cycle where valid&ready both 1; next accept earliest the
//   cycle after DONE->IDLE (no same-cycle result/operand overlap).
//  Latency, no polling wait: 4 accesses*(STROBE_CYC+2) cycles from accept to res_valid
//   (16 at default); each extra poll adds STROBE_CYC+3.
//  poll_cnt width clog2(POLL_LIMIT+1), cleared on accept; no wrap.
//  Operands forwarded verbatim, incl. zero; GCD semantics belong to the slave.
//  Async reset mid-transaction: strobes drop immediately (combinational clear via reg
//   reset), no partial result emitted; slave state is not the master's concern.
// STRUCTURE
//  Shared package/header: register address constants, STATUS_DONE_BIT, FSM state
//   encodings, bus phase encodings.
//  One sub-module: gpio_bus_access — single read/write cycle engine (start, rnw,
//   addr, wdata -> busy, done, rdata); FSM sequences it.
// TESTING (bench instantiates gcd_bus_master driving gpioemu)
//  op_a=39, op_b=9, res_ready=1 -> writes 0x27@0xf8, 0x9@0xfc; res_data=3, timeout=0.
//  op 48,18 with res_ready=0 for 20 cyc -> res_valid held, res_data=6 stable, op_ready=0.
//  100 back-to-back ops (39,9) -> 100 results of 3; slave counter on gpio_out = 100.
//  Stub slave never sets status bit0, POLL_LIMIT=4 -> exactly 4 status reads,
//   res_valid=1, res_timeout=1, res_data=0.
//  n_reset pulsed low during WR_A2 strobe -> swr=0 that instant, op_ready=1 after
//   release, next op 12,8 returns 4.
//  Bus checker every test: srd&swr never both 1; addr/data stable SETUP..HOLD.

Source files
------------

// File: rtl/gcd_bus_master_pkg.sv
// ---------------------------------------------------------------------------
// gcd_bus_master_pkg
//   Shared definitions for the GCD bus master: default register map of the
//   gpioemu GCD peripheral, the status done bit, FSM state and bus phase
//   encodings, and the bus request record passed from the sequencer to the
//   single-access engine.
// ---------------------------------------------------------------------------
package gcd_bus_master_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] DEF_A1_ADDR     = 16'h00f8;
    localparam logic [ADDR_W-1:0] DEF_A2_ADDR     = 16'h00fc;
    localparam logic [ADDR_W-1:0] DEF_STATUS_ADDR = 16'h00f4;
    localparam logic [ADDR_W-1:0] DEF_RESULT_ADDR = 16'h00f0;

    localparam int STATUS_DONE_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_A1,
        ST_WR_A2,
        ST_RD_STAT,
        ST_GAP,
        ST_RD_RES,
        ST_DONE
    } gcd_state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_STROBE,
        PH_HOLD
    } bus_phase_e;

    typedef struct packed {
        logic              rnw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    function automatic bus_req_t mk_req(input logic              rnw,
                                        input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] wdata);
        bus_req_t r;
        r.rnw   = rnw;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/gcd_bus_master_if.sv
// ---------------------------------------------------------------------------
// gcd_bus_master_if
//   Bundles the operand port, result port and gpioemu register bus of the
//   GCD bus master.
//   master modport : view of gcd_bus_master (drives op_ready, res_*, bus)
//   slave  modport : view of the surrounding fabric + gpioemu slave
// ---------------------------------------------------------------------------
interface gcd_bus_master_if;
    import gcd_bus_master_pkg::*;

    // operand port
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    // result port
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_timeout;
    // register bus
    logic [ADDR_W-1:0] saddress;
    logic              srd;
    logic              swr;
    logic [DATA_W-1:0] sdata_wr;
    logic [DATA_W-1:0] sdata_rd;

    modport master (
        input  op_valid, op_a, op_b, res_ready, sdata_rd,
        output op_ready, res_valid, res_data, res_timeout,
               saddress, srd, swr, sdata_wr
    );

    modport slave (
        output op_valid, op_a, op_b, res_ready, sdata_rd,
        input  op_ready, res_valid, res_data, res_timeout,
               saddress, srd, swr, sdata_wr
    );

endinterface

// File: rtl/gcd_bus_master_gpio_bus_access.sv
// ---------------------------------------------------------------------------
// gpio_bus_access
//   Runs one gpioemu register access: SETUP (1 cycle, address/data driven,
//   strobes low) -> STROBE (STROBE_CYC cycles, srd or swr high) -> HOLD
//   (1 cycle, strobes low, address/data still held). Read data is sampled on
//   the last STROBE cycle. A new start accepted in HOLD chains the next
//   access with no idle cycle in between.
//   Ports:
//     clk, n_reset        clock, async active-low reset
//     start_i, req_i      launch an access (accepted in idle or HOLD)
//     sdata_rd_i          slave read data
//     busy_o              access in flight
//     done_o              access in HOLD (rdata_o valid for reads)
//     rdata_o             last sampled read data
//     saddress_o, srd_o, swr_o, sdata_wr_o   registered bus outputs
// ---------------------------------------------------------------------------
module gpio_bus_access
    import gcd_bus_master_pkg::*;
#(
    parameter int STROBE_CYC = 2
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              start_i,
    input  bus_req_t          req_i,
    input  logic [DATA_W-1:0] sdata_rd_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [ADDR_W-1:0] saddress_o,
    output logic              srd_o,
    output logic              swr_o,
    output logic [DATA_W-1:0] sdata_wr_o
);

    localparam int CW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STROBE_CYC - 1);

    bus_phase_e        phase_q;
    logic [CW-1:0]     cnt_q;
    logic              rnw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              srd_q;
    logic              swr_q;
    logic [DATA_W-1:0] rdata_q;

    // Strobes are plain registers so the async reset pulls them low at once.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            srd_q   <= 1'b0;
            swr_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (phase_q)
                PH_IDLE, PH_HOLD: begin
                    if (start_i) begin
                        phase_q <= PH_SETUP;
                        rnw_q   <= req_i.rnw;
                        addr_q  <= req_i.addr;
                        wdata_q <= req_i.wdata;
                    end else begin
                        // idle bus parks address/data at zero
                        phase_q <= PH_IDLE;
                        rnw_q   <= 1'b0;
                        addr_q  <= '0;
                        wdata_q <= '0;
                    end
                end
                PH_SETUP: begin
                    phase_q <= PH_STROBE;
                    cnt_q   <= '0;
                    srd_q   <= rnw_q;
                    swr_q   <= ~rnw_q;
                end
                PH_STROBE: begin
                    if (cnt_q == CNT_LAST) begin
                        phase_q <= PH_HOLD;
                        srd_q   <= 1'b0;
                        swr_q   <= 1'b0;
                        if (rnw_q) rdata_q <= sdata_rd_i;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: phase_q <= PH_IDLE;
            endcase
        end
    end

    assign busy_o     = (phase_q != PH_IDLE);
    assign done_o     = (phase_q == PH_HOLD);
    assign rdata_o    = rdata_q;
    assign saddress_o = addr_q;
    assign srd_o      = srd_q;
    assign swr_o      = swr_q;
    assign sdata_wr_o = wdata_q;

endmodule

// File: rtl/gcd_bus_master.sv
// ---------------------------------------------------------------------------
// gcd_bus_master
//   Drives the gpioemu GCD peripheral from fabric logic. Takes an operand
//   pair on a valid/ready port, writes A1 then A2 (which starts the GCD),
//   polls status until the done bit is set (or POLL_LIMIT reads elapse),
//   reads the result and offers it on a valid/ready result port.
//   Ports:
//     clk, n_reset   clock, async active-low reset
//     bus (master)   op_valid/op_ready/op_a/op_b    operand handshake
//                    res_valid/res_ready/res_data/res_timeout  result
//                    saddress/srd/swr/sdata_wr/sdata_rd        slave bus
// ---------------------------------------------------------------------------
module gcd_bus_master
    import gcd_bus_master_pkg::*;
#(
    parameter logic [ADDR_W-1:0] A1_ADDR     = DEF_A1_ADDR,
    parameter logic [ADDR_W-1:0] A2_ADDR     = DEF_A2_ADDR,
    parameter logic [ADDR_W-1:0] STATUS_ADDR = DEF_STATUS_ADDR,
    parameter logic [ADDR_W-1:0] RESULT_ADDR = DEF_RESULT_ADDR,
    parameter int                STROBE_CYC  = 2,
    parameter int                POLL_LIMIT  = 1024
) (
    input  logic             clk,
    input  logic             n_reset,
    gcd_bus_master_if.master bus
);

    localparam int PW = $clog2(POLL_LIMIT + 1);

    gcd_state_e        state_q;
    logic              op_ready_q;
    logic [DATA_W-1:0] b_q;
    logic [PW-1:0]     poll_cnt_q;
    logic              res_valid_q;
    logic              res_timeout_q;
    logic [DATA_W-1:0] res_data_q;

    logic              acc_start;
    bus_req_t          acc_req;
    logic              acc_busy;
    logic              acc_done;
    logic [DATA_W-1:0] acc_rdata;

    logic              accept;
    logic              stat_done;
    logic [PW-1:0]     poll_nxt;

    assign accept    = bus.op_valid & op_ready_q & ~acc_busy;
    assign stat_done = acc_rdata[STATUS_DONE_BIT];
    assign poll_nxt  = poll_cnt_q + PW'(1);

    // Next access is launched on the same edge the previous one leaves HOLD
    // (or on the accept edge), so accesses run back to back. op_a goes
    // straight into the engine's data register on the accept edge.
    always_comb begin
        acc_start = 1'b0;
        acc_req   = '0;
        case (state_q)
            ST_IDLE: if (accept) begin
                acc_start = 1'b1;
                acc_req   = mk_req(1'b0, A1_ADDR, bus.op_a);
            end
            ST_WR_A1: if (acc_done) begin
                acc_start = 1'b1;
                acc_req   = mk_req(1'b0, A2_ADDR, b_q);
            end
            ST_WR_A2: if (acc_done) begin
                acc_start = 1'b1;
                acc_req   = mk_req(1'b1, STATUS_ADDR, '0);
            end
            ST_RD_STAT: if (acc_done && stat_done) begin
                acc_start = 1'b1;
                acc_req   = mk_req(1'b1, RESULT_ADDR, '0);
            end
            ST_GAP: begin
                acc_start = 1'b1;
                acc_req   = mk_req(1'b1, STATUS_ADDR, '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= ST_IDLE;
            op_ready_q    <= 1'b1;
            b_q           <= '0;
            poll_cnt_q    <= '0;
            res_valid_q   <= 1'b0;
            res_timeout_q <= 1'b0;
            res_data_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) begin
                    b_q        <= bus.op_b;
                    poll_cnt_q <= '0;
                    op_ready_q <= 1'b0;
                    state_q    <= ST_WR_A1;
                end
                ST_WR_A1: if (acc_done) state_q <= ST_WR_A2;
                ST_WR_A2: if (acc_done) state_q <= ST_RD_STAT;
                ST_RD_STAT: if (acc_done) begin
                    if (stat_done) begin
                        state_q <= ST_RD_RES;
                    end else begin
                        // counter stops at POLL_LIMIT, so it never wraps
                        poll_cnt_q <= poll_nxt;
                        if (poll_nxt == PW'(POLL_LIMIT)) begin
                            state_q       <= ST_DONE;
                            res_valid_q   <= 1'b1;
                            res_timeout_q <= 1'b1;
                            res_data_q    <= '0;
                        end else begin
                            state_q <= ST_GAP;
                        end
                    end
                end
                ST_GAP: state_q <= ST_RD_STAT;
                ST_RD_RES: if (acc_done) begin
                    state_q       <= ST_DONE;
                    res_valid_q   <= 1'b1;
                    res_timeout_q <= 1'b0;
                    res_data_q    <= acc_rdata;
                end
                ST_DONE: if (bus.res_ready) begin
                    // op_ready rises one cycle after the result handshake
                    state_q       <= ST_IDLE;
                    op_ready_q    <= 1'b1;
                    res_valid_q   <= 1'b0;
                    res_timeout_q <= 1'b0;
                    res_data_q    <= '0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    gpio_bus_access #(
        .STROBE_CYC (STROBE_CYC)
    ) u_access (
        .clk        (clk),
        .n_reset    (n_reset),
        .start_i    (acc_start),
        .req_i      (acc_req),
        .sdata_rd_i (bus.sdata_rd),
        .busy_o     (acc_busy),
        .done_o     (acc_done),
        .rdata_o    (acc_rdata),
        .saddress_o (bus.saddress),
        .srd_o      (bus.srd),
        .swr_o      (bus.swr),
        .sdata_wr_o (bus.sdata_wr)
    );

    assign bus.op_ready    = op_ready_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_timeout = res_timeout_q;
    assign bus.res_data    = res_data_q;

endmodule

// File: tb/tb_gcd_bus_master.sv
// ---------------------------------------------------------------------------
// tb_gcd_bus_master
//   Scoreboard bench: directed operand pairs push hand-computed results into
//   a queue, a negedge monitor pops and compares on each result handshake.
//   A behavioural gpioemu-style GCD slave (with adjustable latency and a
//   stub mode that never reports done) answers the bus, and a bus checker
//   watches strobe exclusivity, strobe width and address/data stability.
// ---------------------------------------------------------------------------
module tb_gcd_bus_master;
    import gcd_bus_master_pkg::*;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    gcd_bus_master_if bus_if();

    gcd_bus_master #(
        .POLL_LIMIT (4)
    ) u_dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural slave ----------------
    int          slv_lat = 0;
    logic        stub = 1'b0;
    logic [31:0] sl_a = '0, sl_res = '0;
    int          sl_cnt = 0;
    logic        sl_done = 1'b0;
    int          gpio_out = 0;
    int          stat_reads = 0;
    logic        swr_prev = 1'b0, srd_prev = 1'b0;
    logic [47:0] wlog[$];

    function automatic logic [31:0] gcd_f(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, t;
        x = a; y = b;
        while (y != 0) begin t = x % y; x = y; y = t; end
        return x;
    endfunction

    always @(posedge clk) begin
        swr_prev <= bus_if.swr;
        srd_prev <= bus_if.srd;
        if (bus_if.swr && !swr_prev) begin
            wlog.push_back({bus_if.saddress, bus_if.sdata_wr});
            if (bus_if.saddress == 16'h00f8) sl_a <= bus_if.sdata_wr;
            if (bus_if.saddress == 16'h00fc) begin
                sl_res  <= gcd_f(sl_a, bus_if.sdata_wr);
                sl_cnt  <= slv_lat;
                sl_done <= (slv_lat == 0);
                if (slv_lat == 0) gpio_out <= gpio_out + 1;
            end
        end else if (sl_cnt != 0) begin
            sl_cnt <= sl_cnt - 1;
            if (sl_cnt == 1) begin
                sl_done  <= 1'b1;
                gpio_out <= gpio_out + 1;
            end
        end
        if (bus_if.srd && !srd_prev && bus_if.saddress == 16'h00f4)
            stat_reads <= stat_reads + 1;
    end

    always_comb begin
        bus_if.sdata_rd = 32'h0;
        if (bus_if.srd) begin
            if (bus_if.saddress == 16'h00f4)      bus_if.sdata_rd = {31'b0, sl_done & ~stub};
            else if (bus_if.saddress == 16'h00f0) bus_if.sdata_rd = sl_res;
            else                                  bus_if.sdata_rd = 32'hbad0bad0;
        end
    end

    // ---------------- monitor + bus checker ----------------
    logic [32:0] exp_q[$];
    logic [32:0] mon_exp;
    logic        ck_rd_p = 1'b0, ck_wr_p = 1'b0;
    logic [15:0] ck_addr_p = '0;
    logic [31:0] ck_data_p = '0;
    int          ck_run = 0;

    always @(negedge clk) begin
        if (!n_reset) begin
            ck_rd_p <= 1'b0; ck_wr_p <= 1'b0; ck_run <= 0;
            ck_addr_p <= '0; ck_data_p <= '0;
        end else begin
            if (bus_if.res_valid && bus_if.res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: got %0h with nothing expected",
                             {bus_if.res_timeout, bus_if.res_data});
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("result", {31'b0, bus_if.res_timeout, bus_if.res_data}, {31'b0, mon_exp});
                end
            end
            if (bus_if.srd && bus_if.swr) chk("strobe_excl", 2'b11, 2'b00);
            if (bus_if.srd || bus_if.swr || ck_rd_p || ck_wr_p)
                chk("addr_data_stable", {bus_if.saddress, bus_if.sdata_wr}, {ck_addr_p, ck_data_p});
            if (bus_if.srd || bus_if.swr) ck_run <= ck_run + 1;
            else begin
                if (ck_rd_p || ck_wr_p) chk("strobe_width", 64'(ck_run), 64'd2);
                ck_run <= 0;
            end
            ck_rd_p   <= bus_if.srd;
            ck_wr_p   <= bus_if.swr;
            ck_addr_p <= bus_if.saddress;
            ck_data_p <= bus_if.sdata_wr;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_op(input logic [31:0] a, input logic [31:0] b);
        int n;
        @(posedge clk); #1;
        bus_if.op_valid = 1'b1; bus_if.op_a = a; bus_if.op_b = b;
        n = 0;
        @(negedge clk);
        while (!bus_if.op_ready && n < 300) begin @(negedge clk); n++; end
        if (!bus_if.op_ready) begin
            checks++; errors++;
            $display("FAIL op_accept: op_ready stayed 0, expected 1");
            bus_if.op_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        // later operand changes must not reach the bus
        bus_if.op_valid = 1'b0; bus_if.op_a = 32'hdeadbeef; bus_if.op_b = 32'hcafef00d;
    endtask

    task automatic wait_empty(input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL result_wait: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_valid(output int lat);
        int t0, n;
        t0 = cyc; n = 0;
        while (!bus_if.res_valid && n < 300) begin @(negedge clk); n++; end
        lat = cyc - t0;
        if (!bus_if.res_valid) begin
            checks++; errors++;
            $display("FAIL res_valid_wait: res_valid stayed 0, expected 1");
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int lat, w0, s0, g0, n;
        bus_if.op_valid = 1'b0; bus_if.op_a = '0; bus_if.op_b = '0;
        bus_if.res_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_ctrl", {bus_if.op_ready, bus_if.res_valid, bus_if.res_timeout, bus_if.srd, bus_if.swr}, 5'b10000);
        chk("reset_data", {bus_if.res_data, bus_if.saddress, bus_if.sdata_wr}, '0);
        #2 n_reset = 1'b1;
        repeat (2) @(negedge clk);

        // 39,9 -> 3, no polling wait
        w0 = wlog.size();
        exp_q.push_back({1'b0, 32'd3});
        send_op(32'd39, 32'd9);
        wait_valid(lat);
        chk("latency_nowait", 64'(lat), 64'd16);
        wait_empty(100);
        chk("write_a1", 64'(wlog[w0]),   {16'h0, 16'h00f8, 32'h27});
        chk("write_a2", 64'(wlog[w0+1]), {16'h0, 16'h00fc, 32'h9});

        // zero operand forwarded verbatim; gcd(0,7)=7
        w0 = wlog.size();
        exp_q.push_back({1'b0, 32'd7});
        send_op(32'd0, 32'd7);
        wait_empty(100);
        chk("write_zero", 64'(wlog[w0]), {16'h0, 16'h00f8, 32'h0});

        // slave slow enough to force one extra status poll: 21,14 -> 7
        slv_lat = 8;
        s0 = stat_reads;
        exp_q.push_back({1'b0, 32'd7});
        send_op(32'd21, 32'd14);
        wait_valid(lat);
        chk("latency_1poll", 64'(lat), 64'd21);
        wait_empty(100);
        chk("status_reads_1poll", 64'(stat_reads - s0), 64'd2);
        slv_lat = 0;

        // result held under backpressure: 48,18 -> 6
        bus_if.res_ready = 1'b0;
        exp_q.push_back({1'b0, 32'd6});
        send_op(32'd48, 32'd18);
        wait_valid(lat);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_stable", {bus_if.res_valid, bus_if.op_ready, bus_if.res_timeout, bus_if.res_data},
                {3'b100, 32'd6});
        end
        @(posedge clk); #1 bus_if.res_ready = 1'b1;
        wait_empty(100);

        // 100 back-to-back operations
        g0 = gpio_out;
        for (int i = 0; i < 100; i++) begin
            exp_q.push_back({1'b0, 32'd3});
            send_op(32'd39, 32'd9);
        end
        wait_empty(200);
        chk("gpio_count", 64'(gpio_out - g0), 64'd100);

        // stub slave never completes: timeout after exactly 4 status reads
        stub = 1'b1;
        s0 = stat_reads;
        exp_q.push_back({1'b1, 32'd0});
        send_op(32'd5, 32'd10);
        wait_empty(200);
        chk("status_reads_timeout", 64'(stat_reads - s0), 64'd4);
        stub = 1'b0;

        // reset during the A2 write strobe
        send_op(32'd39, 32'd9);
        n = 0;
        @(negedge clk);
        while (!(bus_if.swr && bus_if.saddress == 16'h00fc) && n < 50) begin @(negedge clk); n++; end
        chk("reach_a2_strobe", {bus_if.swr, bus_if.saddress}, {1'b1, 16'h00fc});
        #2 n_reset = 1'b0;
        #1;
        chk("abort_strobes", {bus_if.swr, bus_if.srd, bus_if.res_valid, bus_if.op_ready}, 4'b0001);
        repeat (2) @(negedge clk);
        #2 n_reset = 1'b1;
        @(negedge clk);
        chk("op_ready_after_reset", {bus_if.op_ready, bus_if.res_valid}, 2'b10);
        exp_q.push_back({1'b0, 32'd4});
        send_op(32'd12, 32'd8);
        wait_empty(100);
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
